// File: rtl/led_scan_capture.sv
// rtl/led_scan_capture.sv - capture of the row-scanned LED GPIO word into red/green frames
// Define LED_CAPTURE_SYNC_EN to add a two-flop input synchronizer for cross-board use.
module led_scan_capture #(
  parameter int SETTLE = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [35:0]       GPIO_1,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels,
  output logic              FrameValid,
  output logic [7:0]        FrameCount,
  output logic              Locked,
  output logic              SeqError
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  typedef enum logic {
    SEEK,
    TRACK
  } state_t;

  logic [35:0]       s_in;
  logic [35:0]       s_word;
  logic [35:0]       prev_word;
  logic [7:0]        stable_cnt;
  logic [7:0]        stable_cnt_next;
  logic              capture;

  logic [3:0]        row_sel;
  logic [15:0]       red_row;
  logic [15:0]       grn_row;

  state_t            state;
  state_t            state_next;
  logic [3:0]        expected;
  logic [3:0]        expected_next;
  logic [3:0]        last_row;
  logic [3:0]        last_row_next;
  logic              row_wr;
  logic              work_clr;
  logic              publish;
  logic              seq_err;

  logic [15:0][15:0] work_red;
  logic [15:0][15:0] work_grn;

`ifdef LED_CAPTURE_SYNC_EN
  logic [35:0] sync1;
  logic [35:0] sync2;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= GPIO_1;
      sync2 <= sync1;
    end
  end

  assign s_in = sync2;
`else
  assign s_in = GPIO_1;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s_word     <= '0;
      prev_word  <= '0;
      stable_cnt <= '0;
    end else begin
      s_word     <= s_in;
      prev_word  <= s_word;
      stable_cnt <= stable_cnt_next;
    end
  end

  always_comb begin
    stable_cnt_next = stable_cnt;
    if (s_word != prev_word) begin
      stable_cnt_next = 8'd1;
    end else if (stable_cnt >= SETTLE_CNT) begin
      stable_cnt_next = SETTLE_CNT;
    end else begin
      stable_cnt_next = stable_cnt + 8'd1;
    end
  end

  // A fresh word with SETTLE=1 lands on SETTLE while the count already sits there.
  assign capture = (stable_cnt_next == SETTLE_CNT) &&
                   ((s_word != prev_word) || (stable_cnt != SETTLE_CNT));

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  assign row_sel = s_word[35:32];
  assign red_row = rev16(s_word[15:0]);
  assign grn_row = rev16(s_word[31:16]);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= SEEK;
      expected <= '0;
      last_row <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
      last_row <= last_row_next;
    end
  end

  always_comb begin
    state_next    = state;
    expected_next = expected;
    last_row_next = last_row;
    row_wr        = 1'b0;
    work_clr      = 1'b0;
    publish       = 1'b0;
    seq_err       = 1'b0;
    if (capture) begin
      if (state == SEEK) begin
        if (row_sel == 4'd0) begin
          row_wr        = 1'b1;
          expected_next = 4'd1;
          last_row_next = 4'd0;
          state_next    = TRACK;
        end
      end else if (row_sel == last_row) begin
        row_wr = 1'b1;
      end else if (row_sel == expected && expected != 4'd15) begin
        row_wr        = 1'b1;
        last_row_next = row_sel;
        expected_next = row_sel + 4'd1;
      end else if (row_sel == expected) begin
        publish       = 1'b1;
        expected_next = 4'd0;
        last_row_next = 4'd15;
      end else begin
        seq_err  = 1'b1;
        work_clr = 1'b1;
        if (row_sel == 4'd0) begin
          row_wr        = 1'b1;
          expected_next = 4'd1;
          last_row_next = 4'd0;
        end else begin
          state_next = SEEK;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      work_red   <= '0;
      work_grn   <= '0;
      RedPixels  <= '0;
      GrnPixels  <= '0;
      FrameValid <= 1'b0;
      FrameCount <= '0;
      Locked     <= 1'b0;
      SeqError   <= 1'b0;
    end else begin
      FrameValid <= publish;
      if (work_clr) begin
        work_red <= '0;
        work_grn <= '0;
      end
      if (row_wr) begin
        work_red[row_sel] <= red_row;
        work_grn[row_sel] <= grn_row;
      end
      // Row 15 goes straight from the sample; it never sits in the work buffer.
      if (publish) begin
        RedPixels  <= {red_row, work_red[14:0]};
        GrnPixels  <= {grn_row, work_grn[14:0]};
        FrameCount <= FrameCount + 8'd1;
        Locked     <= 1'b1;
      end
      if (seq_err) begin
        SeqError <= 1'b1;
        Locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_capture.sv
// tb/tb_led_scan_capture.sv - directed bench for led_scan_capture
module tb_led_scan_capture;

`ifdef LED_CAPTURE_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  logic              CLK;
  logic              Reset;
  logic [35:0]       gpio_a;
  logic [35:0]       gpio_b;
  logic [15:0][15:0] a_red, a_grn, b_red, b_grn;
  logic              a_fv, b_fv, a_lock, b_lock, a_seq, b_seq;
  logic [7:0]        a_fc, b_fc;

  int total = 0;
  int bad   = 0;
  int fv_a  = 0;
  int fv_b  = 0;
  int base;

  led_scan_capture #(.SETTLE(2)) dut_a (
    .CLK(CLK), .Reset(Reset), .GPIO_1(gpio_a),
    .RedPixels(a_red), .GrnPixels(a_grn), .FrameValid(a_fv),
    .FrameCount(a_fc), .Locked(a_lock), .SeqError(a_seq)
  );

  led_scan_capture #(.SETTLE(3)) dut_b (
    .CLK(CLK), .Reset(Reset), .GPIO_1(gpio_b),
    .RedPixels(b_red), .GrnPixels(b_grn), .FrameValid(b_fv),
    .FrameCount(b_fc), .Locked(b_lock), .SeqError(b_seq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (a_fv) fv_a++;
    if (b_fv) fv_b++;
  end

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Patterns are in pixel order: bit c is column c of row r.
  function automatic logic [15:0] pat_red(input int set, input int r);
    case (set)
      0:       return 16'h0001 << r;
      1:       return 16'h0F0F ^ 16'(r);
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] pat_grn(input int set, input int r);
    case (set)
      0:       return ~(16'h0001 << r);
      1:       return 16'h1234 + 16'(r);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [35:0] word(input int set, input int r);
    return {4'(r), rev16(pat_grn(set, r)), rev16(pat_red(set, r))};
  endfunction

  function automatic logic [255:0] frame_red(input int set);
    logic [255:0] f;
    for (int r = 0; r < 16; r++) f[r*16 +: 16] = pat_red(set, r);
    return f;
  endfunction

  function automatic logic [255:0] frame_grn(input int set);
    logic [255:0] f;
    for (int r = 0; r < 16; r++) f[r*16 +: 16] = pat_grn(set, r);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input int set, input int r, input int n);
    gpio_a = word(set, r);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_b(input int set, input int r, input int n);
    gpio_b = word(set, r);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sweep_a(input int set, input int first, input int last, input int n);
    for (int r = first; r <= last; r++) send_a(set, r, n);
  endtask

  task automatic sweep_b(input int set, input int first, input int last, input int n);
    for (int r = first; r <= last; r++) send_b(set, r, n);
  endtask

  initial begin
    Reset  = 1'b1;
    gpio_a = {4'hF, 32'h0};
    gpio_b = {4'hF, 32'h0};
    repeat (3) @(negedge CLK);

    chk("rst_red",   256'(a_red), 256'(0));
    chk("rst_grn",   256'(a_grn), 256'(0));
    chk("rst_fc",    256'(a_fc), 256'(0));
    chk("rst_fv",    256'(a_fv), 256'(0));
    chk("rst_lock",  256'(a_lock), 256'(0));
    chk("rst_seq",   256'(a_seq), 256'(0));
    Reset = 1'b0;
    repeat (4) @(negedge CLK);

    // clean sweep with exact publish latency
    sweep_a(0, 0, 14, 4);
    gpio_a = word(0, 15);
    @(negedge CLK);
    repeat (XL) @(negedge CLK);
    chk("lat_fv_e0", 256'(a_fv), 256'(0));
    @(negedge CLK);
    chk("lat_fv_e1", 256'(a_fv), 256'(0));
    chk("lat_fc_e1", 256'(a_fc), 256'(0));
    @(negedge CLK);
    chk("lat_fv_e2", 256'(a_fv), 256'(1));
    chk("lat_fc_e2", 256'(a_fc), 256'(1));
    chk("clean_red", 256'(a_red), frame_red(0));
    chk("clean_grn", 256'(a_grn), frame_grn(0));
    chk("clean_lock", 256'(a_lock), 256'(1));
    chk("clean_seq", 256'(a_seq), 256'(0));
    @(negedge CLK);
    chk("lat_fv_pulse", 256'(a_fv), 256'(0));
    repeat (4) @(negedge CLK);
    chk("clean_fvcnt", 256'(fv_a), 256'(1));

    // reset, then a sweep that starts at row 5
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    chk("rst2_red", 256'(a_red), 256'(0));
    chk("rst2_fc", 256'(a_fc), 256'(0));
    chk("rst2_lock", 256'(a_lock), 256'(0));
    sweep_a(0, 5, 15, 4);
    repeat (4) @(negedge CLK);
    chk("late_nofc", 256'(a_fc), 256'(0));
    chk("late_nofv", 256'(fv_a), 256'(1));
    sweep_a(0, 0, 15, 4);
    repeat (4) @(negedge CLK);
    chk("late_fc", 256'(a_fc), 256'(1));
    chk("late_fvcnt", 256'(fv_a), 256'(2));
    chk("late_lock", 256'(a_lock), 256'(1));
    chk("late_seq", 256'(a_seq), 256'(0));

    // out of order rows 0,1,2,4
    sweep_a(1, 0, 2, 4);
    send_a(1, 4, 4);
    repeat (4) @(negedge CLK);
    chk("ooo_seq", 256'(a_seq), 256'(1));
    chk("ooo_lock", 256'(a_lock), 256'(0));
    chk("ooo_fc", 256'(a_fc), 256'(1));
    chk("ooo_red_kept", 256'(a_red), frame_red(0));
    sweep_a(1, 0, 15, 4);
    repeat (4) @(negedge CLK);
    chk("ooo2_fc", 256'(a_fc), 256'(2));
    chk("ooo2_seq", 256'(a_seq), 256'(1));
    chk("ooo2_lock", 256'(a_lock), 256'(1));
    chk("ooo2_red", 256'(a_red), frame_red(1));
    chk("ooo2_grn", 256'(a_grn), frame_grn(1));
    chk("ooo2_fvcnt", 256'(fv_a), 256'(3));

    // glitch rejection on the SETTLE=3 instance
    sweep_b(0, 0, 3, 4);
    send_b(0, 9, 2);
    sweep_b(0, 4, 15, 4);
    repeat (4) @(negedge CLK);
    chk("gl_fc", 256'(b_fc), 256'(1));
    chk("gl_seq", 256'(b_seq), 256'(0));
    chk("gl_lock", 256'(b_lock), 256'(1));
    chk("gl_red", 256'(b_red), frame_red(0));
    chk("gl_fvcnt", 256'(fv_b), 256'(1));

    // 256 frames at the minimum row period wrap the counter
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    base = fv_a;
    for (int f = 0; f < 255; f++) sweep_a(0, 0, 15, 2);
    repeat (4) @(negedge CLK);
    chk("wrap_255", 256'(a_fc), 256'(255));
    sweep_a(0, 0, 15, 2);
    repeat (4) @(negedge CLK);
    chk("wrap_0", 256'(a_fc), 256'(0));
    chk("wrap_fvcnt", 256'(fv_a - base), 256'(256));
    chk("wrap_lock", 256'(a_lock), 256'(1));

    // row 7 held with one data change
    base = fv_a;
    sweep_a(1, 0, 6, 2);
    send_a(2, 7, 500);
    send_a(1, 7, 500);
    chk("hold_nofv", 256'(fv_a - base), 256'(0));
    chk("hold_seq", 256'(a_seq), 256'(0));
    chk("hold_fc", 256'(a_fc), 256'(0));
    sweep_a(1, 8, 15, 2);
    repeat (4) @(negedge CLK);
    chk("hold_fc2", 256'(a_fc), 256'(1));
    chk("hold_red", 256'(a_red), frame_red(1));
    chk("hold_grn", 256'(a_grn), frame_grn(1));
    chk("hold_seq2", 256'(a_seq), 256'(0));

    // reset after row 8, resume from row 9
    sweep_a(0, 0, 8, 4);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    chk("mid_red", 256'(a_red), 256'(0));
    chk("mid_grn", 256'(a_grn), 256'(0));
    chk("mid_fc", 256'(a_fc), 256'(0));
    chk("mid_lock", 256'(a_lock), 256'(0));
    Reset = 1'b0;
    base = fv_a;
    sweep_a(0, 9, 15, 4);
    repeat (4) @(negedge CLK);
    chk("mid_nofv", 256'(fv_a - base), 256'(0));
    chk("mid_nofc", 256'(a_fc), 256'(0));
    sweep_a(0, 0, 15, 4);
    repeat (4) @(negedge CLK);
    chk("mid_fc", 256'(a_fc), 256'(1));
    chk("mid_red2", 256'(a_red), frame_red(0));
    chk("mid_lock2", 256'(a_lock), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_capture.md
# led_scan_capture

Receive-side counterpart of the 16x16x2 LED matrix driver. Samples the 36-bit row-scanned GPIO word, which carries a row select, 16 green columns and 16 red columns. Filters out transition glitches, checks that rows arrive in sweep order, and rebuilds complete red/green frames. Used as a loopback checker on the bench and as the input stage of a second board that mirrors the display.

## Interface

Parameters:
- SETTLE, default 2: consecutive cycles a sampled word must stay unchanged before it is captured. Legal range 1..255.

Ports:
- CLK  in  1: system clock.
- Reset  in  1: synchronous, active-high.
- GPIO_1  in  36: scanned word.
  - [35:32] row select.
  - [31:16] green columns, bit 31 = column 0 … bit 16 = column 15.
  - [15:0] red columns, bit 15 = column 0 … bit 0 = column 15.
- RedPixels  out  16x16 ([15:0][15:0], [row][col]): last completed red frame.
- GrnPixels  out  16x16: last completed green frame.
- FrameValid  out  1: one-cycle pulse when RedPixels/GrnPixels update.
- FrameCount  out  8: completed frames, wraps 255→0.
- Locked  out  1: at least one in-order frame completed since the last resync.
- SeqError  out  1: sticky, set on any out-of-order row; cleared only by Reset.

## Operation

Input stage:
- GPIO_1 is registered into sample S every cycle.
- StableCnt counts consecutive cycles S is unchanged. It restarts at 1 when S differs from its previous value and saturates at SETTLE.

Capture:
- Exactly one capture per stable period, in the cycle StableCnt first reaches SETTLE.
- A word that changes before reaching SETTLE is never captured.
- Column decode for captured row r and column c:
  - Red[r][c] = S[15−c]
  - Grn[r][c] = S[31−c]

Sequencing FSM. State registers: state, Expected (4 bits), LastRow (4 bits).

SEEK, entered on reset and after any sequence error:
- Captures of rows other than 0 are ignored.
- A capture of row 0 writes row 0 into the work buffer, sets Expected=1 and LastRow=0, and moves to TRACK.

TRACK, on each capture of row r:
- r == LastRow: the row's data changed while the row was held. Overwrite work row r; no error.
- r == Expected, r ≠ 15: write work row r, set LastRow=r, Expected=r+1.
- r == Expected == 15: publish the frame.
  - RedPixels/GrnPixels take work rows 0–14 plus row 15 decoded directly from S.
  - Pulse FrameValid; FrameCount+1; set Locked.
  - Expected wraps to 0, LastRow=15. Stay in TRACK.
- Any other r:
  - Set SeqError and clear Locked.
  - The partial work buffer is discarded; published outputs are kept.
  - If r == 0, re-enter TRACK exactly as from SEEK (row 0 written, Expected=1). Otherwise go to SEEK.

Other rules:
- A halted scan (row held indefinitely) is not an error and has no timeout. Outputs simply hold.
- Reset dominates every other event in the same cycle, including a capture or a publish.
- Reset values:
  - All pixel outputs and the work buffer are 0.
  - FrameValid, FrameCount, Locked and SeqError are 0.
  - State = SEEK, StableCnt = 0, S = 0.
- Reset mid-frame discards the partial frame; the next frame publishes only after a fresh row 0.

## Timing

- Define e0 as the first CLK edge at which a new word is on GPIO_1. S holds the word after e0.
- Without the sync option, capture takes effect at edge e0+SETTLE.
- For row 15, RedPixels, GrnPixels, FrameCount and Locked update at e0+SETTLE, and FrameValid is high for the cycle after that edge.
- Minimum accepted row period is SETTLE cycles. When the driver uses FREQDIV=0 (row changes every cycle), SETTLE must be 1.
- FrameValid never rises on two consecutive cycles: publishes are at least 16×SETTLE cycles apart.

## Configuration

- LED_CAPTURE_SYNC_EN defined:
  - GPIO_1 passes through a two-flop synchronizer before S, for when GPIO_1 comes from another board's clock domain.
  - Every latency above grows by 2 cycles.
  - Reset clears both synchronizer flops.
- LED_CAPTURE_SYNC_EN undefined:
  - Single input register only, for same-clock loopback.

## Test plan

- Clean sweep: SETTLE=2, each row held 4 cycles, red row r = 16'h0001<<r, green = ~red. After row 15 → one FrameValid pulse, RedPixels[r][r]=1 and all other red bits 0, FrameCount=1, Locked=1, SeqError=0.
- Late start: sweep begins at row 5 → no capture until row 0. The first FrameValid arrives after the following row 15; FrameCount=1.
- Out of order: rows 0,1,2,4 → SeqError=1, Locked=0, state SEEK, outputs unchanged. A subsequent full sweep → FrameValid, FrameCount+1, SeqError stays 1.
- Glitch rejection: SETTLE=3, a 2-cycle word with row 9 injected between rows 3 and 4 → ignored, no SeqError, frame publishes normally.
- Wrap and hold: 256 clean frames → FrameCount=0 again. Then hold row 7 for 1000 cycles with its data changing once → no FrameValid, no SeqError, the next sweep completes normally.
- Reset mid-frame: assert Reset after row 8 is captured, release, continue from row 9 → all outputs 0, no publish until the next full 0–15 sweep.
